fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Program-counter and instruction-fetch stage that sits directly upstream of the multicycle control FSM. Holds the PC and issues word reads to instruction memory. Captures the returned 16-bit instruction into an instruction register and splits it into the opcode/condition/shift fields the FSM decodes. Computes the next PC on the FSM's `pc_en` strobe: sequential, Bcond displacement, Jcond register target, or JAL target with link capture.

## Interface
- `ADDR_W`, 16, PC/memory word-address width; must be ≥ 9
- `RESET_PC`, 0, PC value after reset
- `READ_LATENCY`, 2, cycles from read issue to `mem_rdata` valid; legal range 1–7

- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-low
- `fetch_start` in 1: request a fetch at current PC
- `pc_en` in 1: update PC this cycle
- `branch_en` in 1: with `pc_en`, take Bcond displacement
- `jmp_en` in 1: with `pc_en`, take register target
- `jal_en` in 1: with `pc_en`, take register target and capture link
- `jmp_target` in ADDR_W: Rtarget value from register file
- `mem_rdata` in 16: instruction memory read data
- `mem_addr` out ADDR_W: registered read address
- `mem_rd` out 1: one-cycle read strobe
- `busy` out 1: fetch in flight
- `instr_valid` out 1: one-cycle pulse, IR just loaded
- `ir` out 16: instruction register
- `op1` out 4: ir[15:12]
- `rdest_cond` out 4: ir[11:8], Rdest or condition code
- `op2` out 4: ir[7:4]
- `rsrc_shamt` out 4: ir[3:0]
- `pc` out ADDR_W: current PC
- `link_addr` out ADDR_W: last captured JAL link value

## Operation
- Fetch FSM states: IDLE, WAIT.
  - IDLE + `fetch_start`: `mem_addr` ← pc, `mem_rd` ← 1, counter ← 1, go to WAIT.
  - WAIT: counter increments each cycle. When counter = READ_LATENCY, `ir` ← `mem_rdata`, `instr_valid` ← 1 for one cycle, go to IDLE.
  - `busy` = (state == WAIT).
  - READ_LATENCY = 1 loads IR on the first WAIT cycle.
- `fetch_start` while busy: ignored. No queuing, no error.
- `mem_addr` holds its value until the next issue. `mem_rd` is high exactly one cycle per fetch.
- PC update, only when `pc_en`, priority order:
  1. `jal_en`: pc ← `jmp_target`, `link_addr` ← pc.
  2. `jmp_en`: pc ← `jmp_target`.
  3. `branch_en`: pc ← pc + sext(ir[7:0]).
  4. otherwise: pc ← pc + 1.
- The pc used on the right-hand side is the pre-edge value.
- Arithmetic is modulo 2^ADDR_W. pc = all-ones + 1 → 0. Negative displacement wraps below 0.
- `fetch_start` and `pc_en` in the same cycle: fetch uses the old PC, and PC updates in parallel. This is the normal FETCH-state usage.
- `pc_en` during WAIT is legal. The in-flight fetch is unaffected because its address is already latched.
- `branch_en`/`jmp_en`/`jal_en` without `pc_en`: no effect.
- Field outputs are pure slices of `ir`. They stay stable until the next IR load.

## Timing
- Reset (edge with `reset`=0) forces: pc = RESET_PC, state IDLE, `mem_addr` = RESET_PC, `mem_rd` 0, `busy` 0, `instr_valid` 0, `ir` 0, `link_addr` 0. All field outputs are therefore 0.
- Reset mid-fetch aborts the fetch. Later `mem_rdata` is discarded, and no `instr_valid` pulse follows.
- `fetch_start` sampled at edge N: `mem_rd` high in cycle N..N+1, `ir` loaded at edge N+READ_LATENCY, `instr_valid` high for that one following cycle.
- Default latency of 2 matches the FSM's FETCH→FETCH2→DECODE sequence: IR is valid when DECODE is entered.
- Earliest next fetch: `fetch_start` sampled on the same edge that loads IR. Back-to-back throughput is one fetch per READ_LATENCY cycles.
- `pc`, `link_addr` update at the edge where `pc_en` is sampled. One-cycle latency.

## Structure
- Shared package `cpu_pkg`:
  - field slice positions (OP1_HI/LO etc.)
  - fetch state enum
  - `sext8` function (8→ADDR_W sign extension)
- Counter width $clog2(READ_LATENCY+1).
- One natural sub-module: `next_pc_sel`, the combinational priority mux plus adder. The fetch FSM and registers stay in the top.

## Test plan
- Reset with RESET_PC=0x0010; release; `fetch_start` pulse, memory returns 0x5A07 after 2 cycles -> `mem_addr`=0x0010, `mem_rd` one cycle, `instr_valid` at edge N+2, op1=5, rdest_cond=A, op2=0, rsrc_shamt=7.
- `fetch_start`+`pc_en` same cycle at pc=0x0020, no branch -> fetch address 0x0020, pc=0x0021 next cycle.
- IR=0xC0FE, pc=0x0005, `pc_en`+`branch_en` -> pc=0x0003. With pc=0x0000 and IR=0xC0FF -> pc=0xFFFF (wrap).
- pc=0x0040, `jmp_target`=0x1234, `pc_en`+`jal_en`+`jmp_en`+`branch_en` all high -> pc=0x1234, `link_addr`=0x0040 (JAL wins).
- pc=0xFFFF, `pc_en` only -> pc=0x0000. `fetch_start` pulses while busy -> no second `mem_rd`, single `instr_valid`.
- Reset asserted the cycle after issue -> no `instr_valid`, `ir` stays 0, pc=RESET_PC. Repeat the whole set with READ_LATENCY=1 and 5 -> `instr_valid` exactly READ_LATENCY edges after issue.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// cpu_pkg: instruction field positions, fetch state encoding and displacement sign extension.
// Revision 1.0
package cpu_pkg;

  localparam int OP1_HI  = 15;
  localparam int OP1_LO  = 12;
  localparam int RDC_HI  = 11;
  localparam int RDC_LO  = 8;
  localparam int OP2_HI  = 7;
  localparam int OP2_LO  = 4;
  localparam int RSS_HI  = 3;
  localparam int RSS_LO  = 0;
  localparam int DISP_HI = 7;
  localparam int DISP_LO = 0;

  // Widest address sext8 can produce; callers truncate to their own ADDR_W.
  localparam int MAX_ADDR_W = 32;

  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  function automatic logic [MAX_ADDR_W-1:0] sext8(input logic [7:0] d);
    return {{(MAX_ADDR_W-8){d[7]}}, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_next_pc_sel.sv
`default_nettype none
`timescale 1ns/1ps
// next_pc_sel: priority mux and adders producing the next PC and the JAL link strobe.
// Revision 1.0
module next_pc_sel
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              pc_en,
  input  logic              branch_en,
  input  logic              jmp_en,
  input  logic              jal_en,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [7:0]        disp,
  output logic [ADDR_W-1:0] pc_d,
  output logic              link_we
);

  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_br;

  assign pc_seq = pc_q + ADDR_W'(1);
  // Sum is formed at full package width, then truncated so wrap is modulo 2^ADDR_W.
  assign pc_br  = ADDR_W'(MAX_ADDR_W'(pc_q) + sext8(disp));

  always_comb begin
    pc_d    = pc_q;
    link_we = 1'b0;
    if (pc_en) begin
      if (jal_en) begin
        pc_d    = jmp_target;
        link_we = 1'b1;
      end else if (jmp_en) begin
        pc_d = jmp_target;
      end else if (branch_en) begin
        pc_d = pc_br;
      end else begin
        pc_d = pc_seq;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
`timescale 1ns/1ps
// fetch_pc_unit: program counter plus fixed-latency instruction fetch into the IR.
// Revision 1.0
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_en,
  input  logic              branch_en,
  input  logic              jmp_en,
  input  logic              jal_en,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              busy,
  output logic              instr_valid,
  output logic [15:0]       ir,
  output logic [3:0]        op1,
  output logic [3:0]        rdest_cond,
  output logic [3:0]        op2,
  output logic [3:0]        rsrc_shamt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr
);

  localparam int               CNT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(READ_LATENCY);

  fetch_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              instr_valid_q;
  logic [15:0]       ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] link_q;
  logic              link_we;
  logic              rd_done;
  logic              issue;

  assign rd_done = (state_q == FETCH_WAIT) && (cnt_q == CNT_DONE);
  // A new fetch may be accepted on the very edge that completes the previous one.
  assign issue   = fetch_start && ((state_q == FETCH_IDLE) || rd_done);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FETCH_IDLE;
      cnt_q         <= '0;
      mem_addr_q    <= RESET_PC;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      ir_q          <= '0;
    end else begin
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      if (rd_done) begin
        ir_q          <= mem_rdata;
        instr_valid_q <= 1'b1;
        state_q       <= FETCH_IDLE;
      end else if (state_q == FETCH_WAIT) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (issue) begin
        mem_addr_q <= pc_q;
        mem_rd_q   <= 1'b1;
        cnt_q      <= CNT_ONE;
        state_q    <= FETCH_WAIT;
      end
    end
  end

  next_pc_sel #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_sel (
    .pc_en     (pc_en),
    .branch_en (branch_en),
    .jmp_en    (jmp_en),
    .jal_en    (jal_en),
    .pc_q      (pc_q),
    .jmp_target(jmp_target),
    .disp      (ir_q[DISP_HI:DISP_LO]),
    .pc_d      (pc_d),
    .link_we   (link_we)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      link_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (link_we) begin
        link_q <= pc_q;
      end
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign busy        = (state_q == FETCH_WAIT);
  assign instr_valid = instr_valid_q;
  assign ir          = ir_q;
  assign op1         = ir_q[OP1_HI:OP1_LO];
  assign rdest_cond  = ir_q[RDC_HI:RDC_LO];
  assign op2         = ir_q[OP2_HI:OP2_LO];
  assign rsrc_shamt  = ir_q[RSS_HI:RSS_LO];
  assign pc          = pc_q;
  assign link_addr   = link_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fetch_pc_unit: three instances (latency 2, 1, 5) driven in lockstep against a cycle model.
module tb_fetch_pc_unit;

  localparam int          N   = 3;
  localparam logic [15:0] RPC = 16'h0010;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start, pc_en, branch_en, jmp_en, jal_en;
  logic [15:0] jmp_target;

  logic [15:0] mem_rdata [N];
  logic [15:0] mem_addr  [N];
  logic [15:0] ir        [N];
  logic [15:0] pc        [N];
  logic [15:0] link      [N];
  logic        mem_rd    [N];
  logic        busy      [N];
  logic        iv        [N];
  logic [3:0]  op1 [N];
  logic [3:0]  rdc [N];
  logic [3:0]  op2 [N];
  logic [3:0]  rss [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fetch_pc_unit #(
      .ADDR_W      (16),
      .RESET_PC    (RPC),
      .READ_LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 5))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_start(fetch_start),
      .pc_en      (pc_en),
      .branch_en  (branch_en),
      .jmp_en     (jmp_en),
      .jal_en     (jal_en),
      .jmp_target (jmp_target),
      .mem_rdata  (mem_rdata[g]),
      .mem_addr   (mem_addr[g]),
      .mem_rd     (mem_rd[g]),
      .busy       (busy[g]),
      .instr_valid(iv[g]),
      .ir         (ir[g]),
      .op1        (op1[g]),
      .rdest_cond (rdc[g]),
      .op2        (op2[g]),
      .rsrc_shamt (rss[g]),
      .pc         (pc[g]),
      .link_addr  (link[g])
    );
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [L=%0d] got %h expected %h at %0t", nm, lat_of(k), act, exp, $time);
    end
  endtask

  // Instruction memory: explicit words where tests need them, address-derived filler elsewhere.
  logic [15:0] imem [logic [15:0]];
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (imem.exists(a)) return imem[a];
    return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
  endfunction

  // Memory returns data only in the cycle that precedes the load edge; garbage otherwise.
  int          age [N] = '{0, 0, 0};
  logic [15:0] req_addr [N];
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_rd[k] === 1'b1) begin
        age[k]      = 1;
        req_addr[k] = mem_addr[k];
      end else if (age[k] > 0 && age[k] < 100) begin
        age[k]++;
      end
      mem_rdata[k] = (age[k] == lat_of(k)) ? mem_word(req_addr[k]) : 16'hEEEE;
    end
  end

  // Behavioural model: remaining-cycles countdown per outstanding fetch, integer PC arithmetic.
  logic [15:0] m_pc [N], m_link [N], m_addr [N], m_ir [N];
  logic        m_rd [N], m_iv [N];
  int          m_rem [N];
  bit          started = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin : m_upd
      logic [15:0] old_pc;
      logic [15:0] old_ir;
      int          d;
      if (!reset) begin
        m_pc[k] = RPC; m_link[k] = 16'h0; m_addr[k] = RPC; m_ir[k] = 16'h0;
        m_rd[k] = 1'b0; m_iv[k] = 1'b0; m_rem[k] = 0;
      end else begin
        old_pc  = m_pc[k];
        old_ir  = m_ir[k];
        m_rd[k] = 1'b0;
        m_iv[k] = 1'b0;
        if (m_rem[k] > 0) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_ir[k] = mem_word(m_addr[k]);
            m_iv[k] = 1'b1;
          end
        end
        if (fetch_start && m_rem[k] == 0) begin
          m_addr[k] = old_pc;
          m_rd[k]   = 1'b1;
          m_rem[k]  = lat_of(k);
        end
        if (pc_en) begin
          if (jal_en) begin
            m_link[k] = old_pc;
            m_pc[k]   = jmp_target;
          end else if (jmp_en) begin
            m_pc[k] = jmp_target;
          end else if (branch_en) begin
            d = int'(old_ir[7:0]);
            if (d > 127) d = d - 256;
            m_pc[k] = 16'((int'(old_pc) + d + 65536) % 65536);
          end else begin
            m_pc[k] = 16'((int'(old_pc) + 1) % 65536);
          end
        end
      end
    end
    if (!reset) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < N; k++) begin
        chk("pc",          k, pc[k],       m_pc[k]);
        chk("link_addr",   k, link[k],     m_link[k]);
        chk("mem_addr",    k, mem_addr[k], m_addr[k]);
        chk("mem_rd",      k, mem_rd[k],   m_rd[k]);
        chk("busy",        k, busy[k],     m_rem[k] > 0);
        chk("instr_valid", k, iv[k],       m_iv[k]);
        chk("ir",          k, ir[k],       m_ir[k]);
        chk("op1",         k, op1[k],      m_ir[k][15:12]);
        chk("rdest_cond",  k, rdc[k],      m_ir[k][11:8]);
        chk("op2",         k, op2[k],      m_ir[k][7:4]);
        chk("rsrc_shamt",  k, rss[k],      m_ir[k][3:0]);
      end
    end
  end

  task automatic step(input logic fs, input logic pe, input logic be, input logic je,
                      input logic jl, input logic [15:0] tgt);
    fetch_start = fs; pc_en = pe; branch_en = be; jmp_en = je; jal_en = jl; jmp_target = tgt;
    @(negedge clk);
    fetch_start = 1'b0; pc_en = 1'b0; branch_en = 1'b0; jmp_en = 1'b0; jal_en = 1'b0;
    jmp_target = 16'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic set_pc(input logic [15:0] v);
    step(0, 1, 0, 1, 0, v);
  endtask

  int first_iv [N];
  int rd_cnt   [N];
  int iv_cnt   [N];

  initial begin
    imem[16'h0010] = 16'h5A07;
    imem[16'h0030] = 16'hC0FE;
    imem[16'h0031] = 16'hC0FF;
    reset = 1'b0;
    fetch_start = 1'b0; pc_en = 1'b0; branch_en = 1'b0; jmp_en = 1'b0; jal_en = 1'b0;
    jmp_target = 16'h0;
    @(negedge clk);
    idle(2);
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("reset pc",       k, pc[k],       16'h0010);
      chk("reset ir",       k, ir[k],       16'h0000);
      chk("reset mem_addr", k, mem_addr[k], 16'h0010);
      chk("reset link",     k, link[k],     16'h0000);
      chk("reset busy",     k, busy[k],     1'b0);
    end

    // First fetch from RESET_PC; instr_valid must appear exactly READ_LATENCY edges later.
    step(1, 0, 0, 0, 0, 16'h0);
    for (int k = 0; k < N; k++) begin
      chk("issue mem_rd",   k, mem_rd[k],   1'b1);
      chk("issue mem_addr", k, mem_addr[k], 16'h0010);
      first_iv[k] = 0;
    end
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      for (int k = 0; k < N; k++) if (iv[k] === 1'b1 && first_iv[k] == 0) first_iv[k] = i;
    end
    for (int k = 0; k < N; k++) begin
      chk("iv latency",  k, first_iv[k], lat_of(k));
      chk("ir 5A07",     k, ir[k],       16'h5A07);
      chk("op1 5",       k, op1[k],      4'h5);
      chk("rdc A",       k, rdc[k],      4'hA);
      chk("op2 0",       k, op2[k],      4'h0);
      chk("rss 7",       k, rss[k],      4'h7);
    end

    // Fetch and sequential PC update in the same cycle.
    set_pc(16'h0020);
    step(1, 1, 0, 0, 0, 16'h0);
    for (int k = 0; k < N; k++) begin
      chk("fetch+pc_en addr", k, mem_addr[k], 16'h0020);
      chk("fetch+pc_en pc",   k, pc[k],       16'h0021);
    end
    idle(6);

    // Negative displacement from IR=C0FE.
    set_pc(16'h0030);
    step(1, 0, 0, 0, 0, 16'h0);
    idle(6);
    set_pc(16'h0005);
    step(0, 1, 1, 0, 0, 16'h0);
    for (int k = 0; k < N; k++) chk("branch -2", k, pc[k], 16'h0003);

    // Wrap below zero with IR=C0FF, then wrap past all-ones.
    set_pc(16'h0031);
    step(1, 0, 0, 0, 0, 16'h0);
    idle(6);
    set_pc(16'h0000);
    step(0, 1, 1, 0, 0, 16'h0);
    for (int k = 0; k < N; k++) chk("branch wrap", k, pc[k], 16'hFFFF);
    step(0, 1, 0, 0, 0, 16'h0);
    for (int k = 0; k < N; k++) chk("seq wrap", k, pc[k], 16'h0000);

    // JAL has top priority; selects without pc_en do nothing.
    set_pc(16'h0040);
    step(0, 1, 1, 1, 1, 16'h1234);
    for (int k = 0; k < N; k++) begin
      chk("jal pc",   k, pc[k],   16'h1234);
      chk("jal link", k, link[k], 16'h0040);
    end
    step(0, 0, 1, 1, 1, 16'h5555);
    for (int k = 0; k < N; k++) chk("no pc_en", k, pc[k], 16'h1234);

    // fetch_start on the cycle after issue: ignored unless that edge completes the fetch.
    for (int k = 0; k < N; k++) begin rd_cnt[k] = 0; iv_cnt[k] = 0; end
    for (int i = 0; i < 10; i++) begin
      step(i < 2, 0, 0, 0, 0, 16'h0);
      for (int k = 0; k < N; k++) begin
        if (mem_rd[k] === 1'b1) rd_cnt[k]++;
        if (iv[k] === 1'b1) iv_cnt[k]++;
      end
    end
    for (int k = 0; k < N; k++) begin
      chk("busy rd count", k, rd_cnt[k], (k == 1) ? 2 : 1);
      chk("busy iv count", k, iv_cnt[k], (k == 1) ? 2 : 1);
    end

    // PC update while a fetch is in flight.
    step(1, 0, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 0, 16'h0);
    idle(6);

    // Reset one cycle after issue aborts the fetch.
    step(1, 0, 0, 0, 0, 16'h0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    for (int k = 0; k < N; k++) iv_cnt[k] = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      for (int k = 0; k < N; k++) if (iv[k] === 1'b1) iv_cnt[k]++;
    end
    for (int k = 0; k < N; k++) begin
      chk("abort iv", k, iv_cnt[k], 0);
      chk("abort ir", k, ir[k],     16'h0000);
      chk("abort pc", k, pc[k],     16'h0010);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
